// File: rtl/btn_event_ctrl.sv
// Turns N debounced active-low button levels into one stream of key events:
// press, release, long-press and auto-repeat, sharing one valid/ready output channel.
module btn_event_ctrl #(
  parameter int                N_BTN         = 4,
  parameter int                ID_W          = 2,
  parameter int                CNT_W         = 24,
  parameter logic [CNT_W-1:0]  LONG_CYCLES   = 24'd5000000,
  parameter logic [CNT_W-1:0]  REPEAT_CYCLES = 24'd1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic [1:0]       evt_type,
  output logic [N_BTN-1:0] btn_held,
  output logic             evt_drop
);

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} state_t;

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_LONG    = 2'b10;
  localparam logic [1:0] EV_REPEAT  = 2'b11;

  localparam logic [CNT_W-1:0] LONG_LAST = LONG_CYCLES - 1'b1;
  localparam logic [CNT_W-1:0] REP_LAST  = REPEAT_CYCLES - 1'b1;

  logic [N_BTN-1:0] btn_prev, fall, rise, emit, pend, grant;
  logic [1:0]       emit_type [N_BTN];
  logic [1:0]       pend_type [N_BTN];
  state_t           state     [N_BTN];
  state_t           nxt_state [N_BTN];
  logic [CNT_W-1:0] timer     [N_BTN];
  logic [CNT_W-1:0] nxt_timer [N_BTN];
  logic             load, sel_found;
  logic [ID_W-1:0]  sel_idx, rr_ptr, cand;

  assign fall = btn_prev & ~btn_n;
  assign rise = ~btn_prev & btn_n;

  // Per-button press FSM; a release wins over a timer expiry on the same edge.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      nxt_state[i] = state[i];
      nxt_timer[i] = timer[i];
      emit[i]      = 1'b0;
      emit_type[i] = EV_PRESS;
      case (state[i])
        S_IDLE: begin
          if (fall[i]) begin
            nxt_state[i] = S_PRESSED;
            nxt_timer[i] = '0;
            emit[i]      = 1'b1;
            emit_type[i] = EV_PRESS;
          end
        end
        S_PRESSED: begin
          if (rise[i]) begin
            nxt_state[i] = S_IDLE;
            nxt_timer[i] = '0;
            emit[i]      = 1'b1;
            emit_type[i] = EV_RELEASE;
          end else if (timer[i] == LONG_LAST) begin
            nxt_state[i] = S_HELD;
            nxt_timer[i] = '0;
            emit[i]      = 1'b1;
            emit_type[i] = EV_LONG;
          end else begin
            nxt_timer[i] = timer[i] + 1'b1;
          end
        end
        S_HELD: begin
          if (rise[i]) begin
            nxt_state[i] = S_IDLE;
            nxt_timer[i] = '0;
            emit[i]      = 1'b1;
            emit_type[i] = EV_RELEASE;
          end else if (timer[i] == REP_LAST) begin
            nxt_timer[i] = '0;
            emit[i]      = 1'b1;
            emit_type[i] = EV_REPEAT;
          end else begin
            nxt_timer[i] = timer[i] + 1'b1;
          end
        end
        default: nxt_state[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev <= '1;
      btn_held <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state[i] <= S_IDLE;
        timer[i] <= '0;
      end
    end else begin
      btn_prev <= btn_n;
      for (int i = 0; i < N_BTN; i++) begin
        state[i]    <= nxt_state[i];
        timer[i]    <= nxt_timer[i];
        btn_held[i] <= (nxt_state[i] != S_IDLE);
      end
    end
  end

  // Round-robin search starts one past the last granted button.
  always_comb begin
    load      = !evt_valid || evt_ready;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N_BTN);
      if (!sel_found && pend[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
    for (int i = 0; i < N_BTN; i++) begin
      grant[i] = load && sel_found && (sel_idx == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_type  <= '0;
      evt_drop  <= 1'b0;
      rr_ptr    <= ID_W'(N_BTN - 1);
      for (int i = 0; i < N_BTN; i++) pend_type[i] <= '0;
    end else begin
      evt_drop <= |(emit & pend & ~grant);
      for (int i = 0; i < N_BTN; i++) begin
        if (emit[i]) begin
          pend[i]      <= 1'b1;
          pend_type[i] <= emit_type[i];
        end else if (grant[i]) begin
          pend[i] <= 1'b0;
        end
      end
      if (load) begin
        if (sel_found) begin
          evt_valid <= 1'b1;
          evt_id    <= sel_idx;
          evt_type  <= pend_type[sel_idx];
          rr_ptr    <= sel_idx;
        end else begin
          evt_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl with LONG_CYCLES=8, REPEAT_CYCLES=4, four buttons.
module tb_btn_event_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [1:0] evt_type;
  logic [3:0] btn_held;
  logic       evt_drop;

  btn_event_ctrl #(
    .N_BTN(4), .ID_W(2), .CNT_W(24),
    .LONG_CYCLES(24'd8), .REPEAT_CYCLES(24'd4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_id(evt_id), .evt_type(evt_type),
    .btn_held(btn_held), .evt_drop(evt_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int id; int typ; int cyc;} ev_t;
  typedef struct {int idx; int low; int n_long; int n_rep;} vec_t;

  ev_t  q[$];
  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_err = 0;
  int   held_cnt = 0;
  int   held_idx = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input int typ, input int c);
    ev_t e;
    e.id = id; e.typ = typ; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int c, h0;
    rst_n = 1'b0;
    btn_n = 4'hF;
    evt_ready = 1'b1;
    vecs[0] = '{idx: 2, low: 3,  n_long: 0, n_rep: 0};
    vecs[1] = '{idx: 0, low: 20, n_long: 1, n_rep: 2};
    vecs[2] = '{idx: 1, low: 8,  n_long: 0, n_rep: 0};
    vecs[3] = '{idx: 3, low: 9,  n_long: 1, n_rep: 0};
    vecs[4] = '{idx: 2, low: 12, n_long: 1, n_rep: 0};
    vecs[5] = '{idx: 1, low: 13, n_long: 1, n_rep: 1};

    fork
      forever begin
        ev_t e;
        @(negedge clk);
        if (btn_held[held_idx]) held_cnt++;
        if (rst_n && evt_valid && evt_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_evt_id", int'(evt_id), -1);
          end else begin
            e = q.pop_front();
            chk("evt_id", int'(evt_id), e.id);
            chk("evt_type", int'(evt_type), e.typ);
            chk("evt_cycle", cyc, e.cyc);
          end
        end
      end
    join_none

    #12;
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_id", int'(evt_id), 0);
    chk("rst_type", int'(evt_type), 0);
    chk("rst_held", int'(btn_held), 0);
    chk("rst_drop", int'(evt_drop), 0);
    do_reset();

    // Single-button hold lengths around the long/repeat boundaries.
    for (int v = 0; v < 6; v++) begin
      tick();
      c = cyc;
      held_idx = vecs[v].idx;
      h0 = held_cnt;
      btn_n[vecs[v].idx] = 1'b0;
      push(vecs[v].idx, 0, c + 2);
      if (vecs[v].n_long != 0) push(vecs[v].idx, 2, c + 10);
      for (int r = 1; r <= vecs[v].n_rep; r++) push(vecs[v].idx, 3, c + 10 + 4 * r);
      repeat (vecs[v].low) tick();
      btn_n[vecs[v].idx] = 1'b1;
      push(vecs[v].idx, 1, c + vecs[v].low + 2);
      repeat (4) tick();
      chk("held_cycles", held_cnt - h0, vecs[v].low);
    end
    chk("queue_drained_table", q.size(), 0);

    // Simultaneous presses from fresh pointer: id1 first, then id3.
    do_reset();
    tick();
    c = cyc;
    btn_n[1] = 1'b0; btn_n[3] = 1'b0;
    push(1, 0, c + 2);
    push(3, 0, c + 3);
    repeat (3) tick();
    btn_n[1] = 1'b1; btn_n[3] = 1'b1;
    push(1, 1, c + 5);
    push(3, 1, c + 6);
    repeat (5) tick();
    chk("queue_drained_rr", q.size(), 0);

    // Backpressure: stable output, overwrite of a pending slot raises evt_drop.
    do_reset();
    evt_ready = 1'b0;
    tick();
    c = cyc;
    btn_n[0] = 1'b0;
    repeat (2) tick();
    chk("bp_valid", int'(evt_valid), 1);
    chk("bp_id", int'(evt_id), 0);
    chk("bp_type", int'(evt_type), 0);
    repeat (2) tick();
    chk("bp_stable_valid", int'(evt_valid), 1);
    chk("bp_stable_type", int'(evt_type), 0);
    btn_n[0] = 1'b1;
    tick();
    chk("bp_no_drop_rel0", int'(evt_drop), 0);
    chk("bp_stable_id", int'(evt_id), 0);
    btn_n[1] = 1'b0;
    tick();
    chk("bp_no_drop_press1", int'(evt_drop), 0);
    btn_n[1] = 1'b1;
    tick();
    chk("bp_drop_pulse", int'(evt_drop), 1);
    tick();
    chk("bp_drop_cleared", int'(evt_drop), 0);
    c = cyc;
    evt_ready = 1'b1;
    push(0, 0, c);
    push(1, 1, c + 1);
    push(0, 1, c + 2);
    repeat (4) tick();
    chk("queue_drained_bp", q.size(), 0);

    // Async reset mid-HELD with a stalled event, then press seen from reset release.
    evt_ready = 1'b0;
    btn_n[2] = 1'b0;
    repeat (12) tick();
    chk("held_before_rst", int'(btn_held[2]), 1);
    chk("valid_before_rst", int'(evt_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", int'(evt_valid), 0);
    chk("async_id", int'(evt_id), 0);
    chk("async_type", int'(evt_type), 0);
    chk("async_held", int'(btn_held), 0);
    chk("async_drop", int'(evt_drop), 0);
    q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    evt_ready = 1'b1;
    c = cyc;
    push(2, 0, c + 2);
    repeat (4) tick();
    chk("held_after_rst", int'(btn_held[2]), 1);
    btn_n[2] = 1'b1;
    push(2, 1, c + 6);
    repeat (4) tick();
    chk("queue_drained_final", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
